axi_probe_target: RTL and testbench
===================================

# axi_probe_target

AXI-lite style responder (slave) for the UART probe's AXI master port: a small word-addressed register memory that accepts read/write address, write data and returns read data and write responses. Sits on the far side of the probe's AXI bus in bring-up and simulation builds, so probe commands have a deterministic, checkable target. Read and write channels are independent FSMs; ready signals are registered pulses issued only in reply to a pending valid.

## Interface
- DEPTH, 16: number of 32-bit words; power of two, 2..256.
- STALL_CYCLES, 3: extra response delay in cycles (0..15); used only with `AXI_TARGET_STALL_EN`.
- clk  input  1  clock; all logic on rising edge.
- m_aresetn  input  1  asynchronous active-low reset.
- s_axi_araddr  input  32  read byte address.
- s_axi_arsize  input  3  ignored.
- s_axi_arvalid  input  1  read address valid.
- s_axi_arready  output  1  read address accept pulse.
- s_axi_rdata  output  32  read data.
- s_axi_rresp  output  2  read response.
- s_axi_rvalid  output  1  read data valid.
- s_axi_rready  input  1  read data accept.
- s_axi_awaddr  input  32  write byte address.
- s_axi_awsize  input  3  ignored.
- s_axi_awvalid  input  1  write address valid.
- s_axi_awready  output  1  write address accept pulse.
- s_axi_wdata  input  32  write data.
- s_axi_wstrb  input  4  byte enables.
- s_axi_wvalid  input  1  write data valid.
- s_axi_wready  output  1  write data accept pulse.
- s_axi_bresp  output  2  write response.
- s_axi_bvalid  output  1  write response valid.
- s_axi_bready  input  1  write response accept.

## Operation
- Reset: all outputs 0; both FSMs idle; memory cleared to 0.
- Word index = addr[log2(DEPTH)+1:2]; addr[1:0] ignored. Address >= DEPTH*4 is out of range: resp DECERR (2'b11), write suppressed, rdata 0. In range: resp OKAY (2'b00).
- Ready rule: arready/awready/wready are registered, high exactly one cycle, asserted the cycle after the corresponding valid is seen high while the channel is waiting and ready is low. Handshake = valid && ready at that edge. Never held high idle.
- Read FSM: R_IDLE -> (ar handshake, latch addr) R_READ -> R_STALL (if configured) -> R_RESP. R_READ registers memory word into rdata and sets rresp. R_RESP: rvalid=1, rdata/rresp stable until rready; on rvalid&&rready -> R_IDLE, rvalid=0 next cycle.
- Write FSM: W_COLLECT accepts AW and W in either order or same cycle, each latched once (flags aw_got, w_got); extra valids ignored until return to W_COLLECT. Both got -> W_COMMIT: bytes with wstrb[i]=1 written, others kept; wstrb=0 writes nothing, still OKAY. -> W_STALL (if configured) -> W_RESP: bvalid=1 until bready; then -> W_COLLECT with flags cleared.
- Simultaneous read sample (R_READ) and write commit (W_COMMIT) to same word: read returns pre-write data.
- rready/bready high with no valid: ignored.
- Reset mid-transaction: returns to reset state immediately; in-flight transaction lost, no response.

## Timing
- Read: arvalid rise at cycle 0 -> arready at 1 -> R_READ at 2 -> rvalid at 3 (+STALL_CYCLES if enabled). Min read turnaround arvalid->rvalid = 3 cycles.
- Write: both valids at cycle 0 -> awready and wready at 1 -> commit at 2 -> bvalid at 3 (+STALL_CYCLES). Memory updated at cycle-2 edge.
- One outstanding transaction per channel; next arready no earlier than cycle after rvalid&&rready.
- Compatible with masters that drop valid on seeing ready and that tie rready=rvalid / bready=bvalid (single-cycle rvalid/bvalid).

## Configuration
- `AXI_TARGET_STALL_EN` defined: R_STALL/W_STALL present; 4-bit down-counter loaded with STALL_CYCLES delays rvalid/bvalid by exactly STALL_CYCLES cycles (0 = no delay).
- Undefined: no stall states or counter; STALL_CYCLES ignored; timing as minimum above.

## Test plan
- Reset: hold m_aresetn low 3 cycles mid-read -> all outputs 0; read of addr 0x0 afterwards -> rdata 0x00000000, rresp 0.
- Write addr 0x8 data 0xCAFEF00D wstrb 4'hF, then read 0x8 -> bresp 0, rdata 0xCAFEF00D, rvalid at cycle 3 after arvalid (stall disabled).
- Partial write: word 0x4 = 0x11223344, write 0x000000AA wstrb 4'b0001 -> read 0x4 = 0x112233AA.
- AW at cycle 0, W at cycle 5 -> awready at 1, wready at 6, bvalid at 8; single commit.
- Out of range (DEPTH=16): write 0x40 data 0x5 then read 0x40 -> bresp 2'b11, rresp 2'b11, rdata 0; words 0..15 unchanged.
- With `AXI_TARGET_STALL_EN`, STALL_CYCLES=3: read 0x0 -> rvalid at cycle 6; hold rready low 4 cycles -> rvalid/rdata stable until accepted.

Source files
------------

// File: rtl/axi_probe_target.sv
// axi_probe_target
//   AXI-lite style responder used as the far-side target of the UART probe's
//   AXI master. Holds DEPTH 32-bit words, answers reads and writes with
//   OKAY (2'b00) in range and DECERR (2'b11) out of range.
//
//   Read and write channels run independent FSMs. The ready outputs are
//   single-cycle registered pulses raised only in reply to a pending valid.
//
// Optional feature (compile-time macro):
//   AXI_TARGET_STALL_EN - adds R_STALL/W_STALL states and a 4-bit down-counter
//                         that delays rvalid/bvalid by STALL_CYCLES cycles.
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two, 2..256)
//   STALL_CYCLES extra response delay (0..15), only with AXI_TARGET_STALL_EN
//
// Ports:
//   clk, m_aresetn                       clock, async active-low reset
//   s_axi_ar* / s_axi_r*                 read address / read data channels
//   s_axi_aw* / s_axi_w* / s_axi_b*      write address / data / response
//   s_axi_arsize, s_axi_awsize           accepted but ignored
module axi_probe_target #(
  parameter int DEPTH        = 16,
  parameter int STALL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        m_aresetn,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arsize,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] STALL_LOAD = 4'(STALL_CYCLES);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] R_IDLE    = 2'd0;
  localparam logic [1:0] R_READ    = 2'd1;
  localparam logic [1:0] R_RESP    = 2'd3;
  localparam logic [1:0] W_COLLECT = 2'd0;
  localparam logic [1:0] W_COMMIT  = 2'd1;
  localparam logic [1:0] W_RESP    = 2'd3;
`ifdef AXI_TARGET_STALL_EN
  localparam logic [1:0] R_STALL   = 2'd2;
  localparam logic [1:0] W_STALL   = 2'd2;
`endif

  // Word address (byte address >> 2) lies beyond the last word.
  function automatic logic word_oor(input logic [29:0] word_addr);
    return (word_addr >> IDX_W) != 30'd0;
  endfunction

  // Byte-lane merge: lanes with strb=1 take the new byte, others keep old.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0] mem_r [DEPTH];

  logic [1:0]  rstate_r;
  logic        arready_r;
  logic [29:0] raddr_r;
  logic [31:0] rdata_r;
  logic [1:0]  rresp_r;
  logic        rvalid_r;

  logic [1:0]  wstate_r;
  logic        awready_r;
  logic        wready_r;
  logic        aw_got_r;
  logic        w_got_r;
  logic [29:0] waddr_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;
  logic [1:0]  bresp_r;
  logic        bvalid_r;

  logic        aw_hs_s;
  logic        w_hs_s;

`ifdef AXI_TARGET_STALL_EN
  logic [3:0]  rcnt_r;
  logic [3:0]  wcnt_r;
`endif

  // Size fields and the byte offset carry no meaning for a word memory.
  logic unused_s;
`ifdef AXI_TARGET_STALL_EN
  assign unused_s = ^{s_axi_arsize, s_axi_awsize, s_axi_araddr[1:0], s_axi_awaddr[1:0]};
`else
  assign unused_s = ^{s_axi_arsize, s_axi_awsize, s_axi_araddr[1:0], s_axi_awaddr[1:0],
                      STALL_LOAD};
`endif

  assign aw_hs_s = s_axi_awvalid && awready_r;
  assign w_hs_s  = s_axi_wvalid && wready_r;

  // Read channel FSM: accept AR, sample memory, present R until accepted.
  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      rstate_r  <= R_IDLE;
      arready_r <= 1'b0;
      raddr_r   <= 30'd0;
      rdata_r   <= 32'd0;
      rresp_r   <= RESP_OKAY;
      rvalid_r  <= 1'b0;
`ifdef AXI_TARGET_STALL_EN
      rcnt_r    <= 4'd0;
`endif
    end else begin
      case (rstate_r)
        R_IDLE: begin
          // arready is a one-cycle pulse; it drops whether or not the
          // master kept valid up, so it is never parked high.
          if (arready_r) begin
            arready_r <= 1'b0;
            if (s_axi_arvalid) begin
              raddr_r  <= s_axi_araddr[31:2];
              rstate_r <= R_READ;
            end
          end else if (s_axi_arvalid) begin
            arready_r <= 1'b1;
          end
        end
        R_READ: begin
          // Sampled with the pre-edge memory value, so a same-cycle commit
          // to this word is not visible to this read.
          if (word_oor(raddr_r)) begin
            rdata_r <= 32'd0;
            rresp_r <= RESP_DECERR;
          end else begin
            rdata_r <= mem_r[raddr_r[IDX_W-1:0]];
            rresp_r <= RESP_OKAY;
          end
`ifdef AXI_TARGET_STALL_EN
          if (STALL_LOAD == 4'd0) begin
            rvalid_r <= 1'b1;
            rstate_r <= R_RESP;
          end else begin
            rcnt_r   <= STALL_LOAD;
            rstate_r <= R_STALL;
          end
`else
          rvalid_r <= 1'b1;
          rstate_r <= R_RESP;
`endif
        end
`ifdef AXI_TARGET_STALL_EN
        R_STALL: begin
          if (rcnt_r <= 4'd1) begin
            rcnt_r   <= 4'd0;
            rvalid_r <= 1'b1;
            rstate_r <= R_RESP;
          end else begin
            rcnt_r <= rcnt_r - 4'd1;
          end
        end
`endif
        R_RESP: begin
          if (s_axi_rready) begin
            rvalid_r <= 1'b0;
            rstate_r <= R_IDLE;
          end
        end
        default: begin
          arready_r <= 1'b0;
          rvalid_r  <= 1'b0;
          rstate_r  <= R_IDLE;
        end
      endcase
    end
  end

  // Write channel FSM and memory: collect AW/W once each, commit, respond.
  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      wstate_r  <= W_COLLECT;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      aw_got_r  <= 1'b0;
      w_got_r   <= 1'b0;
      waddr_r   <= 30'd0;
      wdata_r   <= 32'd0;
      wstrb_r   <= 4'd0;
      bresp_r   <= RESP_OKAY;
      bvalid_r  <= 1'b0;
`ifdef AXI_TARGET_STALL_EN
      wcnt_r    <= 4'd0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else begin
      case (wstate_r)
        W_COLLECT: begin
          // Once a channel has been captured its ready stays low, so any
          // further valids are left pending until the response completes.
          if (awready_r) begin
            awready_r <= 1'b0;
            if (s_axi_awvalid) begin
              aw_got_r <= 1'b1;
              waddr_r  <= s_axi_awaddr[31:2];
            end
          end else if (s_axi_awvalid && !aw_got_r) begin
            awready_r <= 1'b1;
          end
          if (wready_r) begin
            wready_r <= 1'b0;
            if (s_axi_wvalid) begin
              w_got_r <= 1'b1;
              wdata_r <= s_axi_wdata;
              wstrb_r <= s_axi_wstrb;
            end
          end else if (s_axi_wvalid && !w_got_r) begin
            wready_r <= 1'b1;
          end
          if ((aw_got_r || aw_hs_s) && (w_got_r || w_hs_s)) begin
            wstate_r <= W_COMMIT;
          end
        end
        W_COMMIT: begin
          if (word_oor(waddr_r)) begin
            bresp_r <= RESP_DECERR;
          end else begin
            mem_r[waddr_r[IDX_W-1:0]] <= merge_bytes(mem_r[waddr_r[IDX_W-1:0]],
                                                     wdata_r, wstrb_r);
            bresp_r <= RESP_OKAY;
          end
`ifdef AXI_TARGET_STALL_EN
          if (STALL_LOAD == 4'd0) begin
            bvalid_r <= 1'b1;
            wstate_r <= W_RESP;
          end else begin
            wcnt_r   <= STALL_LOAD;
            wstate_r <= W_STALL;
          end
`else
          bvalid_r <= 1'b1;
          wstate_r <= W_RESP;
`endif
        end
`ifdef AXI_TARGET_STALL_EN
        W_STALL: begin
          if (wcnt_r <= 4'd1) begin
            wcnt_r   <= 4'd0;
            bvalid_r <= 1'b1;
            wstate_r <= W_RESP;
          end else begin
            wcnt_r <= wcnt_r - 4'd1;
          end
        end
`endif
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_r <= 1'b0;
            aw_got_r <= 1'b0;
            w_got_r  <= 1'b0;
            wstate_r <= W_COLLECT;
          end
        end
        default: begin
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          aw_got_r  <= 1'b0;
          w_got_r   <= 1'b0;
          bvalid_r  <= 1'b0;
          wstate_r  <= W_COLLECT;
        end
      endcase
    end
  end

  assign s_axi_arready = arready_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = rresp_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_bvalid  = bvalid_r;

endmodule

// File: tb/tb_axi_probe_target.sv
// tb_axi_probe_target
//   Directed, table-driven bench for axi_probe_target (DEPTH=16,
//   STALL_CYCLES=3). Each table row is one write or read with its expected
//   response; hand-written sequences cover reset mid-read, same-word
//   read/write collision, stray ready inputs and a full memory sweep.
module tb_axi_probe_target;

`ifdef AXI_TARGET_STALL_EN
  localparam int STL = 3;
`else
  localparam int STL = 0;
`endif

  logic        clk;
  logic        m_aresetn;
  logic [31:0] s_axi_araddr;
  logic [2:0]  s_axi_arsize;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [31:0] s_axi_awaddr;
  logic [2:0]  s_axi_awsize;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;

  int n_cmp;
  int n_bad;
  logic [31:0] exp_mem [16];

  axi_probe_target #(.DEPTH(16), .STALL_CYCLES(3)) dut (
    .clk          (clk),
    .m_aresetn    (m_aresetn),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arsize (s_axi_arsize),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awsize (s_axi_awsize),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          rdy_dly;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_merge(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    end
    return r;
  endfunction

  // Starts at #1 after a rising edge (cycle 0); returns at the same phase.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input logic [1:0] exp_resp, input string nm);
    int aw_cyc, w_cyc, b_cyc, aw_cnt, w_cnt, exp_b;
    logic [1:0] bresp_seen;
    logic hs_pend, done;
    aw_cyc = -1; w_cyc = -1; b_cyc = -1; aw_cnt = 0; w_cnt = 0;
    bresp_seen = 2'b00; hs_pend = 1'b0; done = 1'b0;
    exp_b = ((aw_dly > w_dly) ? aw_dly : w_dly) + 3 + STL;
    s_axi_awaddr = addr;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    s_axi_bready = 1'b1;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      if (hs_pend) begin
        check({nm, "/bvalid_drop"}, 64'(s_axi_bvalid), 64'd0);
        done = 1'b1;
      end else begin
        if (s_axi_awready) begin aw_cnt++; if (aw_cyc < 0) aw_cyc = cyc; end
        if (s_axi_wready)  begin w_cnt++;  if (w_cyc < 0)  w_cyc  = cyc; end
        if (s_axi_bvalid) begin
          b_cyc = cyc; bresp_seen = s_axi_bresp; hs_pend = 1'b1;
        end
        s_axi_awvalid = (cyc >= aw_dly) && (aw_cyc < 0 || aw_cyc == cyc);
        s_axi_wvalid  = (cyc >= w_dly)  && (w_cyc < 0  || w_cyc == cyc);
      end
      @(posedge clk); #1;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    check({nm, "/awready_cycle"}, 64'(aw_cyc), 64'(aw_dly + 1));
    check({nm, "/wready_cycle"},  64'(w_cyc),  64'(w_dly + 1));
    check({nm, "/awready_pulses"}, 64'(aw_cnt), 64'd1);
    check({nm, "/wready_pulses"},  64'(w_cnt),  64'd1);
    check({nm, "/bvalid_cycle"}, 64'(b_cyc), 64'(exp_b));
    check({nm, "/bresp"}, 64'(bresp_seen), 64'(exp_resp));
  endtask

  // Starts at #1 after a rising edge (cycle 0); rready follows rvalid
  // after rdy_dly cycles; rdata/rresp checked on every rvalid cycle.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int rdy_dly, input string nm);
    int ar_cyc, ar_cnt, r_cyc;
    logic hs_pend, done;
    ar_cyc = -1; ar_cnt = 0; r_cyc = -1; hs_pend = 1'b0; done = 1'b0;
    s_axi_araddr = addr;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      if (hs_pend) begin
        check({nm, "/rvalid_drop"}, 64'(s_axi_rvalid), 64'd0);
        done = 1'b1;
      end else begin
        if (s_axi_arready) begin ar_cnt++; if (ar_cyc < 0) ar_cyc = cyc; end
        if (s_axi_rvalid) begin
          if (r_cyc < 0) r_cyc = cyc;
          check({nm, "/rdata"}, 64'(s_axi_rdata), 64'(exp_data));
          check({nm, "/rresp"}, 64'(s_axi_rresp), 64'(exp_resp));
        end
        s_axi_arvalid = (ar_cyc < 0) || (ar_cyc == cyc);
        s_axi_rready  = (r_cyc >= 0) && (cyc >= r_cyc + rdy_dly);
        if (s_axi_rready && s_axi_rvalid) hs_pend = 1'b1;
      end
      @(posedge clk); #1;
    end
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    check({nm, "/arready_cycle"}, 64'(ar_cyc), 64'd1);
    check({nm, "/arready_pulses"}, 64'(ar_cnt), 64'd1);
    check({nm, "/rvalid_cycle"}, 64'(r_cyc), 64'(3 + STL));
  endtask

  task automatic check_all_zero(input string nm);
    check(nm, 64'({s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
                   s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 32'd0;

    vecs[0]  = '{1'b1, 32'h0000_0008, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'hCAFE_F00D};
    vecs[2]  = '{1'b1, 32'h0000_0004, 32'h1122_3344, 4'hF, 0, 0, 0, 2'b00, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0004, 32'h0000_00AA, 4'h1, 1, 1, 0, 2'b00, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 0, 0, 1, 2'b00, 32'h1122_33AA};
    vecs[5]  = '{1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF, 0, 5, 0, 2'b00, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'hA5A5_A5A5};
    vecs[7]  = '{1'b1, 32'h0000_0040, 32'h0000_0005, 4'hF, 0, 0, 0, 2'b11, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 0, 0, 0, 2'b11, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_003C, 32'hDEAD_BEEF, 4'hC, 2, 0, 0, 2'b00, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_003F, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'hDEAD_0000};
    vecs[11] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, 2'b00, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 0, 4, 2'b00, 32'h0};
    vecs[13] = '{1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 4'hF, 0, 0, 0, 2'b11, 32'h0};
    vecs[14] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'hCAFE_F00D};
    vecs[15] = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 0, 0, 0, 2'b11, 32'h0};

    m_aresetn = 1'b0;
    s_axi_araddr = 32'd0; s_axi_arsize = 3'd2; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    s_axi_awaddr = 32'd0; s_axi_awsize = 3'd2; s_axi_awvalid = 1'b0;
    s_axi_wdata = 32'd0; s_axi_wstrb = 4'd0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    m_aresetn = 1'b1;
    @(posedge clk); #1;
    check_all_zero("idle_after_reset");

    // Table-driven transactions.
    for (int v = 0; v < 16; v++) begin
      if (vecs[v].is_wr) begin
        do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].aw_dly, vecs[v].w_dly,
                 vecs[v].exp_resp, $sformatf("vec%0d_wr", v));
        if (vecs[v].addr < 32'd64) begin
          exp_mem[vecs[v].addr[5:2]] = model_merge(exp_mem[vecs[v].addr[5:2]],
                                                   vecs[v].data, vecs[v].strb);
        end
      end else begin
        do_read(vecs[v].addr, vecs[v].exp_rdata, vecs[v].exp_resp, vecs[v].rdy_dly,
                $sformatf("vec%0d_rd", v));
      end
      @(posedge clk); #1;
    end

    // Out-of-range writes must leave every word untouched.
    for (int i = 0; i < 16; i++) begin
      do_read(32'(i * 4), exp_mem[i], 2'b00, 0, $sformatf("sweep%0d", i));
    end

    // Read and commit to the same word in the same cycle: old data returned.
    fork
      do_write(32'h0000_0008, 32'h1234_5678, 4'hF, 0, 0, 2'b00, "collide_wr");
      do_read(32'h0000_0008, 32'hCAFE_F00D, 2'b00, 0, "collide_rd");
    join
    exp_mem[2] = 32'h1234_5678;
    @(posedge clk); #1;
    do_read(32'h0000_0008, 32'h1234_5678, 2'b00, 0, "collide_after");

    // Stray rready/bready with nothing pending.
    s_axi_rready = 1'b1;
    s_axi_bready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("stray_ready_rvalid", 64'(s_axi_rvalid), 64'd0);
      check("stray_ready_bvalid", 64'(s_axi_bvalid), 64'd0);
    end
    s_axi_rready = 1'b0;
    s_axi_bready = 1'b0;

    // Reset held three cycles in the middle of a read.
    s_axi_araddr  = 32'h0000_0008;
    s_axi_arvalid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    m_aresetn = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check_all_zero("midread_reset");
    end
    m_aresetn = 1'b1;
    for (int i = 0; i < 16; i++) exp_mem[i] = 32'd0;
    repeat (4) begin
      @(posedge clk); #1;
      check("lost_read_rvalid", 64'(s_axi_rvalid), 64'd0);
    end
    do_read(32'h0000_0000, 32'h0, 2'b00, 0, "post_reset_rd0");
    @(posedge clk); #1;
    do_read(32'h0000_0008, 32'h0, 2'b00, 0, "post_reset_rd8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
